// File: rtl/student_logic16_seq_if.sv
// Valid/ready bundle for the sliced bitwise logic unit.
// master drives operands and consumes results; slave is the unit.
interface student_logic16_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             any;
  logic             all;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, any, all
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, any, all
  );
endinterface

// File: rtl/student_logic16_seq.sv
// Multi-cycle AND/OR/XOR/NOT unit, SLICE bits per cycle, LSB first.
// Result and reduce flags only update when the last slice lands.
module student_logic16_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  student_logic16_seq_if.slave bus
);

  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SLICE == 0) begin : g_chk_zero
      $error("SLICE must be non-zero");
    end else if (WIDTH % SLICE != 0) begin : g_chk_mod
      $error("WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic             r_any;
  logic             r_all;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_sr;
  logic [WIDTH-1:0] w_acc;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST);
  assign w_base   = 32'(r_cnt) * 32'(SLICE);
  assign w_sa     = r_a[w_base +: SLICE];
  assign w_sb     = r_b[w_base +: SLICE];

  always_comb begin
    w_sr = '0;
    unique case (r_op)
      2'b00: w_sr = w_sa & w_sb;
      2'b01: w_sr = w_sa | w_sb;
      2'b10: w_sr = w_sa ^ w_sb;
      2'b11: w_sr = ~w_sa;
      default: w_sr = '0;
    endcase
  end

  // Accumulator with the current slice merged in; final edge commits it.
  always_comb begin
    w_acc = r_acc;
    w_acc[w_base +: SLICE] = w_sr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_any <= 1'b0;
      r_all <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_op  <= bus.op;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out <= w_acc;
        r_any <= |w_acc;
        r_all <= &w_acc;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out       = r_out;
  assign bus.any       = r_any;
  assign bus.all       = r_all;

endmodule
